// File: rtl/tx_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tx_arb_pkg : shared types and defaults for the UART TX arbiter     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tx_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_SEND    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search starts at ptr   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    valid_o
);

  localparam int IW = $clog2(NREQ);

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       sum;

  // Rotate so bit k is the requester k places after ptr; scanning
  // downwards lets the smallest offset overwrite any later match.
  always_comb begin
    req2     = {req_i, req_i};
    rot      = NREQ'(req2 >> ptr_i);
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_i} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) begin
          sum = sum - (IW+1)'(NREQ);
        end
        winner_o = sum[IW-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tx_arbiter : round-robin sharing of one UART transmitter           |
// | Optional watchdog abort: define TX_ARB_TIMEOUT_EN                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       data_in,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    busy,
  output logic                    err
);

  localparam int            IW      = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] pick_id;
  logic          pick_valid;
  logic [7:0]    bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign bytes[i] = data_in[8*i +: 8];
  end

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .winner_o(pick_id),
    .valid_o (pick_valid)
  );

`ifdef TX_ARB_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_START;
          id_d    = pick_id;
          data_d  = bytes[pick_id];
        end
      end
      ST_START: begin
        state_d = ST_SEND;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      ST_SEND: begin
        if (tx_done) begin
          state_d = ST_RELEASE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_MAX) begin
          state_d = ST_RELEASE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign err = (state_q == ST_RELEASE) & to_q;
`else
  assign err = 1'b0;
`endif

  // Outputs decode straight from the registered state, so reset clears them.
  assign tx_start  = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign tx_data   = data_q;
  assign active_id = id_q;
  assign ack       = (state_q == ST_RELEASE) ? (NREQ'(1) << id_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tx_arbiter : randomized self-checking bench for tx_arbiter      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tx_arbiter;

  localparam int NREQ = 4;
`ifdef TX_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4096;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data_in;
  logic [NREQ-1:0]   ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [1:0]        active_id;
  logic              busy;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_ptr   = 0;
  bit allow_add = 1'b0;

  tx_arbiter #(
    .NREQ       (NREQ),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .active_id(active_id),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first requesting index at or after p, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    tx_done = 1'b0;
    step();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // One grant from an IDLE cycle with req already applied; returns to IDLE.
  task automatic run_transfer(input int d, input bit drop_mid, input bit glitch,
                              output int got_id, output logic [7:0] got_data,
                              output int start_cyc);
    int w;
    int extra;
    logic [7:0] exp_b;
    logic [NREQ-1:0] exp_ack;
    w = model_pick(req, m_ptr);
    exp_b = data_in[8*w +: 8];
    exp_ack = '0;
    exp_ack[w] = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_idle: busy=%b tx_start=%b, expected 0/0", busy, tx_start);
    end
    step();
    start_cyc = cyc;
    got_id = int'(active_id);
    got_data = tx_data;
    n_tests++;
    if (tx_start !== 1'b1 || active_id !== 2'(w) || tx_data !== exp_b || ack !== '0) begin
      n_fail++;
      $display("FAIL start: tx_start=%b id=%0d data=%h ack=%b, expected 1/%0d/%h/0000",
               tx_start, active_id, tx_data, ack, w, exp_b);
    end
    tx_done = glitch;
    for (int k = 1; k <= d; k++) begin
      step();
      tx_done = (k == d);
      if (drop_mid && k == 1) req[w] = 1'b0;
      if (allow_add && !drop_mid && k == 1 && $urandom_range(0, 2) == 0) begin
        extra = int'($urandom_range(0, NREQ - 1));
        if (extra != w && !req[extra]) begin
          req[extra] = 1'b1;
          data_in[8*extra +: 8] = 8'($urandom);
        end
      end
      n_tests++;
      if (tx_start !== 1'b0 || busy !== 1'b1 || ack !== '0 ||
          active_id !== 2'(w) || tx_data !== exp_b) begin
        n_fail++;
        $display("FAIL send: tx_start=%b busy=%b ack=%b id=%0d data=%h, expected 0/1/0000/%0d/%h",
                 tx_start, busy, ack, active_id, tx_data, w, exp_b);
      end
    end
    step();
    tx_done = 1'b0;
    n_tests++;
    if (ack !== exp_ack || busy !== 1'b1 || err !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL release: ack=%b busy=%b err=%b, expected %b/1/0", ack, busy, err, exp_ack);
    end
    req[w] = 1'b0;
    m_ptr = (w + 1) % NREQ;
    step();
    n_tests++;
    if (busy !== 1'b0 || ack !== '0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL post_idle: busy=%b ack=%b tx_start=%b, expected 0/0000/0", busy, ack, tx_start);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'($urandom);
    data_in = 32'($urandom);
    tx_done = 1'b1;
    step();
    step();
    n_tests++;
    if (ack !== '0 || tx_start !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        active_id !== 2'd0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ack=%b start=%b err=%b busy=%b id=%0d data=%h, expected all 0",
               ack, tx_start, err, busy, active_id, tx_data);
    end
    rst_n = 1'b1;
    req = '0;
    tx_done = 1'b0;
    m_ptr = 0;
    step();
    n_tests++;
    if (busy !== 1'b0 || ack !== '0 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b ack=%b start=%b, expected 0", busy, ack, tx_start);
    end
  endtask

  task automatic test_single();
    int id, sc;
    logic [7:0] dat;
    req = 4'b0100;
    data_in[23:16] = 8'hA5;
    run_transfer(4, 1'b0, 1'b0, id, dat, sc);
    n_tests++;
    if (id !== 2 || dat !== 8'hA5) begin
      n_fail++;
      $display("FAIL single: id=%0d data=%h, expected 2/a5", id, dat);
    end
  endtask

  task automatic test_back_to_back();
    int id, sc, prev_sc;
    logic [7:0] dat;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    req = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    prev_sc = 0;
    for (int i = 0; i < 4; i++) begin
      run_transfer(10, 1'b0, 1'b0, id, dat, sc);
      n_tests++;
      if (id !== i || dat !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: id=%0d data=%h, expected %0d/%h", i, id, dat, i, exp_seq[i]);
      end
      if (i > 0) begin
        n_tests++;
        if (sc - prev_sc !== 13) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: start gap=%0d, expected 13", i, sc - prev_sc);
        end
      end
      prev_sc = sc;
    end
  endtask

  task automatic test_fairness();
    int id, sc;
    logic [7:0] dat;
    apply_reset();
    req = 4'b1001;
    data_in = {8'h0F, 8'h00, 8'h00, 8'hF0};
    run_transfer(3, 1'b0, 1'b0, id, dat, sc);
    req[0] = 1'b1;
    run_transfer(3, 1'b0, 1'b0, id, dat, sc);
    n_tests++;
    if (id !== 3 || dat !== 8'h0F) begin
      n_fail++;
      $display("FAIL fairness: id=%0d data=%h, expected 3/0f", id, dat);
    end
    run_transfer(3, 1'b0, 1'b0, id, dat, sc);
    n_tests++;
    if (id !== 0) begin
      n_fail++;
      $display("FAIL fairness_next: id=%0d, expected 0", id);
    end
  endtask

  task automatic test_drop();
    int id, sc;
    logic [7:0] dat;
    req = 4'b0010;
    data_in[15:8] = 8'h3C;
    run_transfer(5, 1'b1, 1'b0, id, dat, sc);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ack !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_tx_done[%0d]: ack=%b busy=%b, expected 0000/0", i, ack, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int id, sc;
    logic [7:0] dat;
    req = 4'b0100;
    data_in[23:16] = 8'hC3;
    step();
    step();
    step();
    n_tests++;
    if (busy !== 1'b1 || active_id !== 2'd2 || tx_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL mid_send: busy=%b id=%0d data=%h, expected 1/2/c3", busy, active_id, tx_data);
    end
    rst_n = 1'b0;
    step();
    n_tests++;
    if (ack !== '0 || tx_start !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        active_id !== 2'd0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: ack=%b start=%b err=%b busy=%b id=%0d data=%h, expected all 0",
               ack, tx_start, err, busy, active_id, tx_data);
    end
    rst_n = 1'b1;
    req = '0;
    m_ptr = 0;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (ack !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_done[%0d]: ack=%b busy=%b, expected 0000/0", i, ack, busy);
      end
      step();
    end
    req = 4'b1010;
    data_in[15:8] = 8'h5C;
    data_in[31:24] = 8'hE7;
    run_transfer(2, 1'b0, 1'b0, id, dat, sc);
    n_tests++;
    if (id !== 1 || dat !== 8'h5C) begin
      n_fail++;
      $display("FAIL ptr_after_reset: id=%0d data=%h, expected 1/5c", id, dat);
    end
    run_transfer(2, 1'b0, 1'b0, id, dat, sc);
  endtask

  task automatic test_random();
    int id, sc, i0;
    logic [7:0] dat;
    allow_add = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          data_in[8*i +: 8] = 8'($urandom);
        end
      end
      if (req == '0) begin
        i0 = int'($urandom_range(0, NREQ - 1));
        req[i0] = 1'b1;
        data_in[8*i0 +: 8] = 8'($urandom);
      end
      run_transfer(int'($urandom_range(1, 6)), $urandom_range(0, 4) == 0,
                   $urandom_range(0, 3) == 0, id, dat, sc);
    end
    allow_add = 1'b0;
    for (int i = 0; i < NREQ && req != '0; i++) begin
      run_transfer(2, 1'b0, 1'b0, id, dat, sc);
    end
  endtask

`ifdef TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0001;
    data_in[7:0] = 8'h5A;
    step();
    n_tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL to_start: tx_start=%b data=%h, expected 1/5a", tx_start, tx_data);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      n_tests++;
      if (busy !== 1'b1 || ack !== '0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: busy=%b ack=%b err=%b, expected 1/0000/0", k, busy, ack, err);
      end
    end
    step();
    n_tests++;
    if (err !== 1'b1 || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL to_abort: err=%b ack=%b, expected 1/0001", err, ack);
    end
    req = '0;
    m_ptr = 1;
    step();
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b0 || ack !== '0) begin
      n_fail++;
      $display("FAIL to_idle: busy=%b err=%b ack=%b, expected 0/0/0000", busy, err, ack);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req = '0;
    data_in = '0;
    tx_done = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one UART transmitter; range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096: watchdog limit in clk cycles; used only under REQ-027.
REQ-003 clk  input  1: single clock; all logic on posedge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 req  input  NREQ: request per requester; held high, with its data stable, until its ack.
REQ-006 data_in  input  8*NREQ: byte per requester, packed; requester i at bits [8i+7:8i].
REQ-007 ack  output  NREQ: one-cycle pulse to the requester whose byte finished.
REQ-008 tx_start  output  1: one-cycle pulse telling the transmitter to load tx_data.
REQ-009 tx_data  output  8: byte presented to the transmitter.
REQ-010 tx_done  input  1: one-cycle pulse from the transmitter at the end of the stop bit.
REQ-011 active_id  output  $clog2(NREQ): index of the current grantee.
REQ-012 busy  output  1: high whenever the FSM is not in IDLE.
REQ-013 err  output  1: one-cycle pulse on watchdog abort; constant 0 when the feature is compiled out.

Function
REQ-014 FSM states: IDLE, START, SEND, RELEASE.
- IDLE->START when any req bit is set.
- START->SEND unconditionally.
- SEND->RELEASE on tx_done.
- RELEASE->IDLE unconditionally.
REQ-015 In IDLE with req != 0, the block picks a winner round-robin: search begins at ptr, wrapping modulo NREQ.
- In the same edge it latches the winner into active_id and its byte into tx_data.
REQ-016 tx_start is high for exactly the START cycle, one cycle after the IDLE cycle that saw req.
REQ-017 tx_data and active_id hold stable from START through RELEASE.
REQ-018 In RELEASE:
- ack[active_id] pulses for one cycle.
- ptr becomes (active_id+1) mod NREQ.
REQ-019 Only one ack bit is high in any cycle; ack is all-zero outside RELEASE.
REQ-020 Minimum per-byte overhead: IDLE, START and RELEASE cycles around SEND. With requests pending, back-to-back grants start at 3 cycles plus the transmit time.
REQ-021 Deassertion of req during START or SEND does not abort; the transfer completes and ack still pulses.
REQ-022 tx_done received in IDLE, START or RELEASE is ignored.
REQ-023 New or simultaneous req changes during a transfer do not alter active_id; they are evaluated at the next IDLE.
REQ-024 Simultaneous req bits in IDLE: the first set bit at or after ptr wins; the others wait; no requester starves.

Reset
REQ-025 While rst_n is low at a posedge:
- FSM goes to IDLE and ptr to 0.
- ack, tx_start, err, busy, active_id and tx_data go to 0.
REQ-026 Reset mid-transfer discards the transfer with no ack; a later stray tx_done is ignored per REQ-022.

Configuration
REQ-027 Macro TX_ARB_TIMEOUT_EN:
- Defined: a counter clears on entering SEND and increments each SEND cycle. If it reaches TIMEOUT_CYC-1 without tx_done, the FSM goes to RELEASE with err pulsed together with ack.
- Undefined: no counter exists; SEND waits indefinitely and err is tied 0.

Structure
REQ-028 Package tx_arb_pkg holds the state enum type and the default constants NREQ_DEF=4 and TIMEOUT_DEF=4096.
REQ-029 Sub-module rr_pick: combinational round-robin picker. Inputs req and ptr; outputs winner index and valid.

Verification
REQ-030 Single request: req=4'b0100, data_in[2]=8'hA5.
- tx_start one cycle later with tx_data=A5 and active_id=2.
- tx_done pulse -> ack=4'b0100 next cycle; busy low after.
REQ-031 All four requesting from reset with bytes 11,22,33,44 and tx_done 10 cycles after each tx_start: tx_data sequence is 11,22,33,44 and ack order is 0,1,2,3.
REQ-032 Fairness: requester 0 re-requests immediately after its ack while 3 is pending. Grant goes to 3 before 0.
REQ-033 Requester 1 drops req mid-SEND: byte still completes and ack[1] pulses. A tx_done in IDLE produces no ack.
REQ-034 rst_n low for 1 cycle during SEND: all outputs 0 next cycle. A following tx_done produces no ack; the next request proceeds normally from ptr=0.
REQ-035 With TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=16 and no tx_done: err and ack pulse together 17 cycles after tx_start, then IDLE.
